// File: rtl/fft_mag_packer_pkg.sv
// Shared definitions for the FFT magnitude packer: frame FSM encoding,
// output saturation limit and the default frame length.
package fft_mag_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } frame_state_e;

  localparam int unsigned MAG_SAT          = 255;
  localparam int          FFT_LEN_LOG2_DEF = 10;

  // Clamp a non-negative magnitude to one byte.
  function automatic logic [7:0] sat_u8(input logic [31:0] v);
    return (v > MAG_SAT) ? 8'(MAG_SAT) : v[7:0];
  endfunction

endpackage

// File: rtl/fft_mag_packer_if.sv
// FFT output stream plus FIFO write port of the magnitude packer.
// master = environment (FFT source and FIFO), slave = the packer.
interface fft_mag_packer_if #(
  parameter int DIN_WIDTH = 16
) ();

  logic                        s_valid;
  logic signed [DIN_WIDTH-1:0] s_re;
  logic signed [DIN_WIDTH-1:0] s_im;
  logic                        s_last;
  logic [7:0]                  wr_data;
  logic                        wr_en;
  logic                        full;
  logic                        almost_full;

  modport master (
    output s_valid, s_re, s_im, s_last, full, almost_full,
    input  wr_data, wr_en
  );

  modport slave (
    input  s_valid, s_re, s_im, s_last, full, almost_full,
    output wr_data, wr_en
  );

endinterface

// File: rtl/fft_abs_mag.sv
// Stages 1-2 of the packer: |re|, |im| then alpha-max-beta-min (max + min/2).
// Valid, last and bin index ride alongside the data.
module fft_abs_mag
  import fft_mag_packer_pkg::*;
#(
  parameter int DIN_WIDTH = 16,
  parameter int BIN_W     = FFT_LEN_LOG2_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid,
  input  logic                        i_last,
  input  logic [BIN_W-1:0]            i_bin,
  input  logic signed [DIN_WIDTH-1:0] i_re,
  input  logic signed [DIN_WIDTH-1:0] i_im,
  output logic                        o_valid,
  output logic                        o_last,
  output logic [BIN_W-1:0]            o_bin,
  output logic [DIN_WIDTH+1:0]        o_sum
);

  localparam int ABS_W = DIN_WIDTH + 1;
  localparam int SUM_W = DIN_WIDTH + 2;

  logic [ABS_W-1:0] w_re_ext, w_im_ext, w_abs_re, w_abs_im;
  logic [ABS_W-1:0] w_max, w_min;
  logic [SUM_W-1:0] w_sum;

  logic             r_s1_valid, r_s1_last;
  logic [BIN_W-1:0] r_s1_bin;
  logic [ABS_W-1:0] r_abs_re, r_abs_im;
  logic             r_s2_valid, r_s2_last;
  logic [BIN_W-1:0] r_s2_bin;
  logic [SUM_W-1:0] r_s2_sum;

  // One extra bit so the most negative input negates without wrapping.
  assign w_re_ext = {i_re[DIN_WIDTH-1], i_re};
  assign w_im_ext = {i_im[DIN_WIDTH-1], i_im};
  assign w_abs_re = w_re_ext[ABS_W-1] ? ((~w_re_ext) + ABS_W'(1)) : w_re_ext;
  assign w_abs_im = w_im_ext[ABS_W-1] ? ((~w_im_ext) + ABS_W'(1)) : w_im_ext;

  assign w_max = (r_abs_re >= r_abs_im) ? r_abs_re : r_abs_im;
  assign w_min = (r_abs_re >= r_abs_im) ? r_abs_im : r_abs_re;
  assign w_sum = SUM_W'(w_max) + SUM_W'(w_min >> 1);

  // NOTE: non-blocking assignments let each stage capture the previous stage's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_bin   <= '0;
      r_abs_re   <= '0;
      r_abs_im   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_bin   <= '0;
      r_s2_sum   <= '0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_last  <= i_last & i_valid;
      r_s1_bin   <= i_bin;
      r_abs_re   <= w_abs_re;
      r_abs_im   <= w_abs_im;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_bin   <= r_s1_bin;
      r_s2_sum   <= w_sum;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_last  = r_s2_last;
  assign o_bin   = r_s2_bin;
  assign o_sum   = r_s2_sum;

endmodule

// File: rtl/fft_mag_packer.sv
// Packs lower-half FFT bin magnitudes into bytes for a FIFO, dropping whole
// frames when the FIFO cannot keep up and flagging frame-length errors.
module fft_mag_packer
  import fft_mag_packer_pkg::*;
#(
  parameter int DIN_WIDTH    = 16,
  parameter int FFT_LEN_LOG2 = FFT_LEN_LOG2_DEF,
  parameter int MAG_SHIFT    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  fft_mag_packer_if.slave        bus,
  output logic                   frame_done,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   sync_err
);

  localparam int                BIN_W   = FFT_LEN_LOG2;
  localparam int                SUM_W   = DIN_WIDTH + 2;
  localparam logic [BIN_W-1:0]  BIN_MAX = '1;

  logic [BIN_W-1:0] r_bin_cnt;
  logic             r_sync_err;

  logic             w_s2_valid, w_s2_last;
  logic [BIN_W-1:0] w_s2_bin;
  logic [SUM_W-1:0] w_s2_sum;

  logic             r_s3_valid, r_s3_last;
  logic [BIN_W-1:0] r_s3_bin;
  logic [7:0]       r_s3_mag;
  frame_state_e     r_state;
  logic             r_frame_done, r_overflow;
  logic [15:0]      r_drop_cnt;

  frame_state_e     w_state_eff, w_state_nxt;
  logic             w_s3_bin0, w_af_drop, w_eligible, w_write, w_full_drop, w_done;

  // A short frame (s_last before the top bin) realigns the counter to bin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_cnt  <= '0;
      r_sync_err <= 1'b0;
    end else if (bus.s_valid) begin
      if (bus.s_last || r_bin_cnt == BIN_MAX) r_bin_cnt <= '0;
      else                                    r_bin_cnt <= r_bin_cnt + BIN_W'(1);
      if (bus.s_last && r_bin_cnt != BIN_MAX) r_sync_err <= 1'b1;
    end
  end

  fft_abs_mag #(
    .DIN_WIDTH (DIN_WIDTH),
    .BIN_W     (BIN_W)
  ) u_abs_mag (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.s_valid),
    .i_last  (bus.s_last),
    .i_bin   (r_bin_cnt),
    .i_re    (bus.s_re),
    .i_im    (bus.s_im),
    .o_valid (w_s2_valid),
    .o_last  (w_s2_last),
    .o_bin   (w_s2_bin),
    .o_sum   (w_s2_sum)
  );

  assign w_s3_bin0 = r_s3_valid && (r_s3_bin == '0);

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_state_eff = r_state;
    w_af_drop   = 1'b0;
    if (w_s3_bin0) begin
      if (!en) begin
        w_state_eff = ST_IDLE;
      end else if (bus.almost_full) begin
        w_state_eff = ST_DROP;
        w_af_drop   = 1'b1;
      end else begin
        w_state_eff = ST_PASS;
      end
    end
    w_eligible  = r_s3_valid && (w_state_eff == ST_PASS) && !r_s3_bin[BIN_W-1];
    // Live full qualifies the strobe so a write never lands on a full FIFO.
    w_write     = w_eligible && !bus.full;
    w_full_drop = w_eligible && bus.full;
    w_done      = r_s3_valid && r_s3_last && (w_state_eff == ST_PASS) && !w_full_drop;
    if (w_full_drop)  w_state_nxt = ST_DROP;
    else if (w_done)  w_state_nxt = ST_IDLE;
    else              w_state_nxt = w_state_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid   <= 1'b0;
      r_s3_last    <= 1'b0;
      r_s3_bin     <= '0;
      r_s3_mag     <= '0;
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_s3_valid   <= w_s2_valid;
      r_s3_last    <= w_s2_last;
      r_s3_bin     <= w_s2_bin;
      r_s3_mag     <= sat_u8(32'(w_s2_sum >> MAG_SHIFT));
      r_state      <= w_state_nxt;
      r_frame_done <= w_done;
      r_overflow   <= w_af_drop | w_full_drop;
      if ((w_af_drop || w_full_drop) && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.wr_en   = w_write;
  assign bus.wr_data = r_s3_mag;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_fft_mag_packer.sv
// Scoreboard bench: stimulus queues the expected bytes, a negedge monitor
// pops and compares on each FIFO write and tallies frame_done/overflow pulses.
module tb_fft_mag_packer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        frame_done;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        sync_err;

  fft_mag_packer_if #(.DIN_WIDTH(16)) bus ();

  fft_mag_packer #(
    .DIN_WIDTH    (16),
    .FFT_LEN_LOG2 (10),
    .MAG_SHIFT    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         n_wr      = 0;
  int         n_wr_full = 0;
  int         n_done    = 0;
  int         n_ovf     = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  // Hand-computed vectors placed at bins 5..8 of the first frame.
  int spec_re [4] = '{100, -32768, -400, 3};
  int spec_im [4] = '{-40, -32768, 300, -2};
  int spec_exp[4] = '{30, 255, 137, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int mag_ref(input int re, input int im);
    int a, b, mx, mn, s;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    s  = (mx + mn / 2) / 4;
    return (s > 255) ? 255 : s;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        n_wr++;
        if (bus.full) n_wr_full++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wr: got write of %0d, required no write", bus.wr_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wr_data", 32'(bus.wr_data), 32'(mon_exp));
        end
      end
      if (frame_done) n_done++;
      if (overflow)   n_ovf++;
    end
  end

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, "_wr_en"},      32'(bus.wr_en),   0);
    check({tag, "_wr_data"},    32'(bus.wr_data), 0);
    check({tag, "_frame_done"}, 32'(frame_done),  0);
    check({tag, "_overflow"},   32'(overflow),    0);
    check({tag, "_drop_cnt"},   32'(drop_cnt),    0);
    check({tag, "_sync_err"},   32'(sync_err),    0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // full is raised when bin full_at sits at the output stage (3 beats after it
  // was driven) and released 60 beats later.
  task automatic run_frame(input bit wr_ok, input int full_at, input int last_at,
                           input int nbins, input bit specials);
    for (int b = 0; b < nbins; b++) begin
      int re, im, ev;
      bit wr;
      re = ((b * 37) % 1000) - 500;
      im = 350 - ((b * 13) % 700);
      ev = mag_ref(re, im);
      if (specials && b >= 5 && b <= 8) begin
        re = spec_re[b-5];
        im = spec_im[b-5];
        ev = spec_exp[b-5];
      end
      wr = wr_ok && (b < 512) && (full_at < 0 || b < full_at);
      if (full_at >= 0 && b == full_at + 3)  bus.full = 1'b1;
      if (full_at >= 0 && b == full_at + 63) bus.full = 1'b0;
      if (specials && b == 5) idle(4);
      bus.s_valid = 1'b1;
      bus.s_re    = 16'(re);
      bus.s_im    = 16'(im);
      bus.s_last  = (b == last_at);
      if (wr) exp_q.push_back(8'(ev));
      @(posedge clk);
      #1;
      if (specials && b == 5) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(negedge clk);
        check("lat_cyc1_wr_en", 32'(bus.wr_en), 0);
        @(negedge clk);
        check("lat_cyc2_wr_en", 32'(bus.wr_en), 0);
        @(negedge clk);
        check("lat_cyc3_wr_en",   32'(bus.wr_en),   1);
        check("lat_cyc3_wr_data", 32'(bus.wr_data), 30);
        @(posedge clk);
        #1;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic frame(input string tag, input bit wr_ok, input int full_at,
                       input int last_at, input int nbins, input bit specials,
                       input int e_wr, input int e_done, input int e_ovf, input int e_drop);
    int wr0, d0, o0;
    wr0 = n_wr;
    d0  = n_done;
    o0  = n_ovf;
    run_frame(wr_ok, full_at, last_at, nbins, specials);
    idle(8);
    check({tag, "_writes"},     n_wr - wr0,      e_wr);
    check({tag, "_frame_done"}, n_done - d0,     e_done);
    check({tag, "_overflow"},   n_ovf - o0,      e_ovf);
    check({tag, "_drop_cnt"},   32'(drop_cnt),   e_drop);
    check({tag, "_queue"},      exp_q.size(),    0);
  endtask

  initial begin
    int w0;
    rst_n           = 1'b1;
    en              = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_re        = '0;
    bus.s_im        = '0;
    bus.s_last      = 1'b0;
    bus.full        = 1'b0;
    bus.almost_full = 1'b0;
    #3;
    do_reset("por");

    en = 1'b1;
    frame("f1_pass", 1'b1, -1, 1023, 1024, 1'b1, 512, 1, 0, 0);
    frame("f2_full", 1'b1, 200, 1023, 1024, 1'b0, 200, 0, 1, 1);

    bus.almost_full = 1'b1;
    frame("f3_af", 1'b0, -1, 1023, 1024, 1'b0, 0, 0, 1, 2);
    bus.almost_full = 1'b0;
    frame("f4_recover", 1'b1, -1, 1023, 1024, 1'b0, 512, 1, 0, 2);

    en = 1'b0;
    frame("f5_en_off", 1'b0, -1, 1023, 1024, 1'b0, 0, 0, 0, 2);
    en = 1'b1;
    check("pre_short_sync_err", 32'(sync_err), 0);

    frame("f6_short", 1'b1, -1, 700, 701, 1'b0, 512, 1, 0, 2);
    check("f6_sync_err", 32'(sync_err), 1);

    // Beats after the short frame restart at bin 0; reset lands with 3 in flight.
    w0 = n_wr;
    run_frame(1'b1, -1, -1, 10, 1'b0);
    do_reset("mid");
    check("mid_writes_before_reset", n_wr - w0, 7);

    frame("f7_after_reset", 1'b1, -1, 1023, 1024, 1'b0, 512, 1, 0, 0);
    check("f7_sync_err", 32'(sync_err), 0);
    check("wr_while_full", n_wr_full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
